i2d_opmux_ctrl: RTL and testbench



---
 rtl/i2d_opmux_ctrl_pkg.sv | 16 +
 rtl/i2d_opmux_ctrl_if.sv | 29 ++
 rtl/i2d_hazard_cmp.sv | 20 ++
 rtl/i2d_opmux_ctrl.sv | 88 ++++++++
 tb/tb_i2d_opmux_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2d_opmux_ctrl_pkg.sv
// Shared encodings for the i2d operand-mux controller: mux select codes and FSM states.
package i2d_opmux_ctrl_pkg;

  localparam logic [1:0] I2D_OPMUX_A_RA    = 2'd0;
  localparam logic [1:0] I2D_OPMUX_A_ID_PC = 2'd1;
  localparam logic [1:0] I2D_OPMUX_B_RB    = 2'd0;
  localparam logic [1:0] I2D_OPMUX_B_ID_PC = 2'd1;
  localparam logic [1:0] I2D_OPMUX_B_IMM   = 2'd2;
  localparam logic [1:0] I2D_OPMUX_ZERO    = 2'd3;

  typedef enum logic {
    I2D_OPCTL_RUN  = 1'b0,
    I2D_OPCTL_BUSY = 1'b1
  } opctl_state_e;

endpackage

// File: rtl/i2d_opmux_ctrl_if.sv
// Decoder-to-controller bundle: decoded ID fields in, operand selects and pipeline qualifiers out.
interface i2d_opmux_ctrl_if;
  logic       id_valid;
  logic       id_a_src;
  logic [1:0] id_b_src;
  logic [4:0] id_rs_a;
  logic [4:0] id_rs_b;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       id_multi;
  logic [3:0] id_cycles;
  logic       ex_stall;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       id_stall;
  logic       ex_valid;

  modport master (
    output id_valid, id_a_src, id_b_src, id_rs_a, id_rs_b, id_rd,
           id_is_load, id_multi, id_cycles, ex_stall,
    input  sel_a, sel_b, id_stall, ex_valid
  );

  modport slave (
    input  id_valid, id_a_src, id_b_src, id_rs_a, id_rs_b, id_rd,
           id_is_load, id_multi, id_cycles, ex_stall,
    output sel_a, sel_b, id_stall, ex_valid
  );
endinterface

// File: rtl/i2d_hazard_cmp.sv
// Load-use comparator: flags an ID instruction that reads the register an in-flight load writes.
module i2d_hazard_cmp (
  input  logic       ld_pend_i,
  input  logic [4:0] ld_rd_i,
  input  logic       id_valid_i,
  input  logic       id_a_src_i,
  input  logic [1:0] id_b_src_i,
  input  logic [4:0] id_rs_a_i,
  input  logic [4:0] id_rs_b_i,
  output logic       hazard_o
);
  logic use_a;
  logic use_b;

  // Only register-file sources can depend on the load; r0 is hardwired and never hazards.
  assign use_a    = (id_a_src_i == 1'b0)  && (id_rs_a_i == ld_rd_i);
  assign use_b    = (id_b_src_i == 2'd0)  && (id_rs_b_i == ld_rd_i);
  assign hazard_o = ld_pend_i && id_valid_i && (ld_rd_i != 5'd0) && (use_a || use_b);

endmodule

// File: rtl/i2d_opmux_ctrl.sv
// Decode-stage operand-mux controller: select codes, one-bubble load-use stall, multi-cycle EX hold.
module i2d_opmux_ctrl
  import i2d_opmux_ctrl_pkg::*;
#(
  parameter logic [1:0] ZERO_SEL = I2D_OPMUX_ZERO
) (
  input logic               clk,
  input logic               rst,
  i2d_opmux_ctrl_if.slave   bus
);

  opctl_state_e state_q;
  logic [3:0]   cnt_q;
  logic         ld_pend_q;
  logic         ld_pend_d;
  logic [4:0]   ld_rd_q;
  logic         ex_valid_q;

  logic         hazard;
  logic         is_run;
  logic         issue;
  logic         start_busy;
  logic [1:0]   sel_a_d;
  logic [1:0]   sel_b_d;

  i2d_hazard_cmp u_hazard_cmp (
    .ld_pend_i  (ld_pend_q),
    .ld_rd_i    (ld_rd_q),
    .id_valid_i (bus.id_valid),
    .id_a_src_i (bus.id_a_src),
    .id_b_src_i (bus.id_b_src),
    .id_rs_a_i  (bus.id_rs_a),
    .id_rs_b_i  (bus.id_rs_b),
    .hazard_o   (hazard)
  );

  assign is_run     = (state_q == I2D_OPCTL_RUN);
  assign issue      = is_run && bus.id_valid && !hazard && !bus.ex_stall;
  assign start_busy = issue && bus.id_multi && (bus.id_cycles >= 4'd2);
  assign ld_pend_d  = issue && bus.id_is_load && (bus.id_rd != 5'd0);

  // Under ex_stall the mux is frozen downstream, so presenting the decoded sources is harmless.
  always_comb begin
    sel_a_d = ZERO_SEL;
    sel_b_d = ZERO_SEL;
    if (!rst && (issue || bus.ex_stall)) begin
      sel_a_d = {1'b0, bus.id_a_src};
      sel_b_d = bus.id_b_src;
    end
  end

  assign bus.sel_a    = sel_a_d;
  assign bus.sel_b    = sel_b_d;
  assign bus.id_stall = !rst && (bus.ex_stall || (is_run && hazard) || !is_run);
  assign bus.ex_valid = ex_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= I2D_OPCTL_RUN;
      cnt_q      <= 4'd0;
      ld_pend_q  <= 1'b0;
      ld_rd_q    <= 5'd0;
      ex_valid_q <= 1'b0;
    end else if (!bus.ex_stall) begin
      ld_pend_q  <= ld_pend_d;
      ld_rd_q    <= bus.id_rd;
      ex_valid_q <= issue;
      case (state_q)
        I2D_OPCTL_RUN: begin
          if (start_busy) begin
            state_q <= I2D_OPCTL_BUSY;
            // The issue cycle and the final BUSY cycle both count toward id_cycles.
            cnt_q   <= bus.id_cycles - 4'd2;
          end
        end
        I2D_OPCTL_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= I2D_OPCTL_RUN;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: state_q <= I2D_OPCTL_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_i2d_opmux_ctrl.sv
// Self-checking bench for i2d_opmux_ctrl: reference model compared every cycle plus directed literal checks.
module tb_i2d_opmux_ctrl;

  logic clk;
  logic rst;
  i2d_opmux_ctrl_if bus ();

  i2d_opmux_ctrl #(.ZERO_SEL(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining hold cycles, the last issued load's target, and ex_valid.
  int   m_hold_left = 0;
  bit   m_ld_live   = 0;
  int   m_ld_rd     = 0;
  bit   m_exv       = 0;

  function automatic bit m_hazard();
    if (rst || !m_ld_live || !bus.id_valid || m_ld_rd == 0) return 0;
    return (bus.id_a_src == 1'b0 && int'(bus.id_rs_a) == m_ld_rd) ||
           (bus.id_b_src == 2'd0 && int'(bus.id_rs_b) == m_ld_rd);
  endfunction

  function automatic bit m_issue();
    return !rst && m_hold_left == 0 && bus.id_valid && !m_hazard() && !bus.ex_stall;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hold_left = 0;
      m_ld_live   = 0;
      m_ld_rd     = 0;
      m_exv       = 0;
    end else if (!bus.ex_stall) begin
      bit iss;
      iss         = m_issue();
      m_exv       = iss;
      m_ld_live   = iss && bus.id_is_load && bus.id_rd != 5'd0;
      m_ld_rd     = int'(bus.id_rd);
      if (m_hold_left > 0)
        m_hold_left = m_hold_left - 1;
      else if (iss && bus.id_multi && bus.id_cycles >= 4'd2)
        m_hold_left = int'(bus.id_cycles) - 1;
    end
  end

  always @(negedge clk) begin
    int ea, eb, es;
    if (rst) begin
      ea = 3; eb = 3; es = 0;
    end else begin
      if (m_issue() || bus.ex_stall) begin
        ea = int'(bus.id_a_src);
        eb = int'(bus.id_b_src);
      end else begin
        ea = 3; eb = 3;
      end
      es = int'(bus.ex_stall || m_hazard() || m_hold_left > 0);
    end
    chk("model_sel_a",    int'(bus.sel_a),    ea);
    chk("model_sel_b",    int'(bus.sel_b),    eb);
    chk("model_id_stall", int'(bus.id_stall), es);
    chk("model_ex_valid", int'(bus.ex_valid), int'(m_exv));
  end

  task automatic op(input bit v, input bit as, input logic [1:0] bs,
                    input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                    input bit ld, input bit mu, input logic [3:0] cy);
    bus.id_valid   = v;
    bus.id_a_src   = as;
    bus.id_b_src   = bs;
    bus.id_rs_a    = ra;
    bus.id_rs_b    = rb;
    bus.id_rd      = rd;
    bus.id_is_load = ld;
    bus.id_multi   = mu;
    bus.id_cycles  = cy;
  endtask

  // Inputs change 1ns after the edge; literal checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int sa, input int sb, input int st);
    #1;
    chk({name, "_sel_a"},    int'(bus.sel_a),    sa);
    chk({name, "_sel_b"},    int'(bus.sel_b),    sb);
    chk({name, "_id_stall"}, int'(bus.id_stall), st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ex_stall = 1'b0;
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 0, 4'd0);
    tick();
    lit("in_reset", 3, 3, 0);
    tick();
    chk("reset_ex_valid", int'(bus.ex_valid), 0);
    rst = 1'b0;

    // ALU stream: RA / IMM
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 2'd2, 5'(i + 1), 5'd0, 5'(i + 8), 0, 0, 4'd0);
      lit("alu_stream", 0, 2, 0);
      if (i >= 1) chk("alu_ex_valid", int'(bus.ex_valid), 1);
      tick();
    end

    // Load r5 then consumer on RB=r5: one bubble
    op(1, 0, 2'd2, 5'd1, 5'd0, 5'd5, 1, 0, 4'd0);
    lit("load5", 0, 2, 0);
    tick();
    op(1, 1, 2'd0, 5'd2, 5'd5, 5'd9, 0, 0, 4'd0);
    lit("bubble", 3, 3, 1);
    tick();
    chk("bubble_ex_valid", int'(bus.ex_valid), 0);
    lit("after_bubble", 1, 0, 0);
    tick();
    chk("dep_issued_ex_valid", int'(bus.ex_valid), 1);

    // Load r0 then rs=0 consumer: no stall
    op(1, 0, 2'd2, 5'd1, 5'd0, 5'd0, 1, 0, 4'd0);
    tick();
    op(1, 0, 2'd0, 5'd0, 5'd0, 5'd4, 0, 0, 4'd0);
    lit("load_r0", 0, 0, 0);
    tick();

    // Load r5 then consumer using IMM for B: no stall
    op(1, 0, 2'd2, 5'd1, 5'd0, 5'd5, 1, 0, 4'd0);
    tick();
    op(1, 0, 2'd2, 5'd1, 5'd5, 5'd4, 0, 0, 4'd0);
    lit("load_imm", 0, 2, 0);
    tick();

    // Load r6 then consumer on RA=r6 (PC on B): bubble through the A path
    op(1, 0, 2'd2, 5'd1, 5'd0, 5'd6, 1, 0, 4'd0);
    tick();
    op(1, 0, 2'd1, 5'd6, 5'd0, 5'd4, 0, 0, 4'd0);
    lit("bubble_a", 3, 3, 1);
    tick();
    lit("after_bubble_a", 0, 1, 0);
    tick();

    // Multi op, 4 cycles
    op(1, 1, 2'd0, 5'd1, 5'd2, 5'd3, 0, 1, 4'd4);
    lit("multi4_issue", 1, 0, 0);
    tick();
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      lit("multi4_busy", 3, 3, 1);
      tick();
    end
    lit("multi4_next", 0, 2, 0);
    tick();

    // id_cycles 0 and 1 never hold
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 1, 4'd0);
    tick();
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 1, 4'd1);
    lit("multi0_next", 0, 2, 0);
    tick();
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 0, 4'd0);
    lit("multi1_next", 0, 2, 0);
    tick();

    // ex_stall right after an issue holds ex_valid high
    bus.ex_stall = 1'b1;
    lit("stall_follow", 0, 2, 1);
    tick();
    tick();
    chk("stall_hold_ex_valid", int'(bus.ex_valid), 1);
    bus.ex_stall = 1'b0;
    tick();

    // ex_stall for 3 cycles in BUSY with cnt=1
    op(1, 0, 2'd0, 5'd1, 5'd2, 5'd3, 0, 1, 4'd4);
    tick();
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 0, 4'd0);
    tick();
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lit("busy_frozen", 0, 2, 1);
      tick();
      chk("busy_frozen_ex_valid", int'(bus.ex_valid), 0);
    end
    bus.ex_stall = 1'b0;
    lit("busy_resume0", 3, 3, 1);
    tick();
    lit("busy_resume1", 3, 3, 1);
    tick();
    lit("busy_done", 0, 2, 0);
    tick();

    // Reset mid-BUSY
    op(1, 0, 2'd0, 5'd1, 5'd2, 5'd3, 0, 1, 4'd5);
    tick();
    rst = 1'b1;
    lit("rst_busy", 3, 3, 0);
    tick();
    rst = 1'b0;
    op(1, 0, 2'd2, 5'd1, 5'd2, 5'd3, 0, 0, 4'd0);
    chk("rst_busy_ex_valid", int'(bus.ex_valid), 0);
    lit("rst_busy_next", 0, 2, 0);
    tick();

    // Reset mid-bubble
    op(1, 0, 2'd2, 5'd1, 5'd0, 5'd7, 1, 0, 4'd0);
    tick();
    op(1, 0, 2'd0, 5'd7, 5'd2, 5'd3, 0, 0, 4'd0);
    lit("pre_rst_bubble", 3, 3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("rst_bubble_next", 0, 0, 0);
    tick();
    chk("rst_bubble_ex_valid", int'(bus.ex_valid), 1);

    op(0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 0, 4'd0);
    lit("idle", 3, 3, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
